// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard controller for the 5-stage pipeline.
// Tracks in-flight register writers from DE issue to WB retire.
// It produces the DE stall, the DE issue permission and the FE/DE flush on a redirect.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int REGIDX   = 5,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,          // async, active-low
    input  logic              de_valid,
    input  logic [REGIDX-1:0] de_rs1,
    input  logic              de_rs1_used,
    input  logic [REGIDX-1:0] de_rs2,
    input  logic              de_rs2_used,
    input  logic [REGIDX-1:0] de_rd,
    input  logic              de_wr_reg,
    input  logic              wb_valid,
    input  logic [REGIDX-1:0] wb_rd,
    input  logic              wb_wr_reg,
    input  logic              agex_br_taken,
    output logic              stall_de,
    output logic              issue_de,
    output logic              flush_fe,
    output logic              flush_de,
    output logic              sb_idle,
    output logic              sb_err,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Entry 0 is held at zero forever, so x0 never looks busy.
    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d [NUM_REGS];
    logic              err_q, err_d;
    logic [PERF_W-1:0] sc_q, sc_d;

    logic raw1, raw2, waw_full;
    logic inc_en, dec_en;

    // Hazard detection from registered counts only; a same-cycle retire is not bypassed.
    always_comb begin
        raw1     = de_rs1_used && (de_rs1 != '0) && (cnt_q[de_rs1] != '0);
        raw2     = de_rs2_used && (de_rs2 != '0) && (cnt_q[de_rs2] != '0);
        waw_full = de_wr_reg   && (de_rd  != '0) && (cnt_q[de_rd] == CNT_MAX);
        // Every combinational output is forced low while reset is held.
        stall_de = reset && de_valid && (raw1 || raw2 || waw_full) && !agex_br_taken;
        issue_de = reset && de_valid && !stall_de && !agex_br_taken;
        flush_fe = reset && agex_br_taken;
        flush_de = reset && agex_br_taken;
        inc_en   = issue_de && de_wr_reg && (de_rd != '0);
        dec_en   = wb_valid && wb_wr_reg && (wb_rd != '0);
    end

    // Next-state counters: inc and dec on the same register cancel out.
    // A retire against an empty counter leaves it at zero and raises the sticky error.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (inc_en && (de_rd == REGIDX'(r)) && !(dec_en && (wb_rd == REGIDX'(r)))) begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end else if (dec_en && (wb_rd == REGIDX'(r)) && !(inc_en && (de_rd == REGIDX'(r)))) begin
                    if (cnt_q[r] == '0) err_d = 1'b1;
                    else                cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end else begin
                cnt_d[r] = '0;
            end
        end
        sc_d = sc_q;
        if (stall_de && (sc_q != PERF_MAX)) sc_d = sc_q + 1'b1;
    end

    // Scoreboard, sticky error and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
            sc_q  <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
            sc_q  <= sc_d;
        end
    end

    // Idle when no register has an outstanding writer.
    always_comb begin
        sb_idle = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) sb_idle = 1'b0;
        end
    end

    assign sb_err       = err_q;
    assign stall_cycles = sc_q;

endmodule
